// File: rtl/gpio_irq_detect.sv
// Per-pin GPIO interrupt detector: pad sync, level/edge trigger, pending valid/ready requests.
// ir_valid rises SYNC_STAGE+1 edges after a pad change is first sampled; requests hold until ir_ready.
module gpio_irq_detect #(
  parameter int WIDTH      = 8,
  parameter int SYNC_STAGE = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   pin_in,
  input  logic [WIDTH-1:0]   dir,
  input  logic [WIDTH-1:0]   en,
  input  logic [WIDTH-1:0]   ie,
  input  logic [2*WIDTH-1:0] trig,
  input  logic               all_mode,
  output logic [WIDTH-1:0]   pin_sync,
  output logic [WIDTH:0]     ir_valid,
  input  logic [WIDTH:0]     ir_ready,
  output logic [WIDTH:0]     ir_overrun
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGE];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH:0]   pending_q;
  logic [WIDTH:0]   overrun_q;

  logic [WIDTH-1:0] armed;
  logic [WIDTH-1:0] hit;
  logic [WIDTH:0]   set;
  logic [WIDTH:0]   handshake;

  assign pin_sync = sync_q[SYNC_STAGE-1];

  always_comb begin
    armed = en & ~dir & ie;
    hit   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (trig[2*i +: 2])
        2'b00: hit[i] = armed[i] & ~pin_sync[i];
        2'b01: hit[i] = armed[i] &  pin_sync[i] & ~prev_q[i];
        2'b10: hit[i] = armed[i] & ~pin_sync[i] &  prev_q[i];
        default: hit[i] = armed[i] & pin_sync[i];
      endcase
    end
    // Combined request needs at least one armed pin and every armed pin hitting.
    set[WIDTH-1:0] = hit & {WIDTH{~all_mode}};
    set[WIDTH]     = all_mode & (|armed) & (&(hit | ~armed));
    handshake      = pending_q & ir_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGE; s++) sync_q[s] <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGE; s++) sync_q[s] <= sync_q[s-1];
      prev_q    <= pin_sync;
      pending_q <= set | (pending_q & ~handshake);
      overrun_q <= (set & pending_q & ~ir_ready) | (overrun_q & ~handshake);
    end
  end

  assign ir_valid   = pending_q;
  assign ir_overrun = overrun_q;

endmodule

// File: tb/tb_gpio_irq_detect.sv
// Directed + random bench for gpio_irq_detect against a rule-level reference model.
module tb_gpio_irq_detect;
  localparam int W = 8;
  localparam int S = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [W-1:0]   pin_in, dir, en, ie;
  logic [2*W-1:0] trig;
  logic           all_mode;
  logic [W-1:0]   pin_sync;
  logic [W:0]     ir_valid, ir_ready, ir_overrun;

  int errors = 0;
  int checks = 0;

  // Model state: last S pad samples (index 0 newest), previous sync value, requests.
  logic [W-1:0] m_hist [S];
  logic [W-1:0] m_prev;
  logic [W:0]   m_pend, m_ovr;

  always #5 clock = ~clock;

  gpio_irq_detect #(.WIDTH(W), .SYNC_STAGE(S)) dut (
    .clock(clock), .reset(reset), .pin_in(pin_in), .dir(dir), .en(en), .ie(ie),
    .trig(trig), .all_mode(all_mode), .pin_sync(pin_sync), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir_overrun(ir_overrun)
  );

  function automatic void model_step();
    logic [W:0] trg;
    int n_armed, n_hit;
    logic s, p, is_level, want, arm, h;
    trg = '0;
    n_armed = 0;
    n_hit = 0;
    if (!reset) begin
      for (int j = 0; j < S; j++) m_hist[j] = '0;
      m_prev = '0; m_pend = '0; m_ovr = '0;
      return;
    end
    for (int i = 0; i < W; i++) begin
      s = m_hist[S-1][i];
      p = m_prev[i];
      arm = en[i] && !dir[i] && ie[i];
      is_level = (trig[2*i +: 2] == 2'b00) || (trig[2*i +: 2] == 2'b11);
      want = (trig[2*i +: 2] == 2'b01) || (trig[2*i +: 2] == 2'b11);
      h = arm && (s == want) && (is_level || s != p);
      if (arm) n_armed++;
      if (h) n_hit++;
      trg[i] = h && !all_mode;
    end
    trg[W] = all_mode && n_armed > 0 && n_hit == n_armed;
    for (int k = 0; k <= W; k++) begin
      if (trg[k] && m_pend[k] && !ir_ready[k]) m_ovr[k] = 1'b1;
      else if (m_pend[k] && ir_ready[k]) m_ovr[k] = 1'b0;
      if (trg[k]) m_pend[k] = 1'b1;
      else if (m_pend[k] && ir_ready[k]) m_pend[k] = 1'b0;
    end
    m_prev = m_hist[S-1];
    for (int j = S-1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = pin_in;
  endfunction

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n = 1);
    for (int c = 0; c < n; c++) begin
      model_step();
      @(posedge clock);
      #1;
      check("pin_sync", {1'b0, pin_sync}, {1'b0, m_hist[S-1]});
      check("ir_valid", ir_valid, m_pend);
      check("ir_overrun", ir_overrun, m_ovr);
    end
  endtask

  initial begin
    for (int j = 0; j < S; j++) m_hist[j] = '0;
    m_prev = '0; m_pend = '0; m_ovr = '0;
    reset = 1'b0; pin_in = '0; dir = '0; en = '1; ie = '1;
    trig = 16'h5555; all_mode = 1'b0; ir_ready = '0;
    cycle(2);
    check("reset_valid", ir_valid, 9'h000);
    check("reset_sync", {1'b0, pin_sync}, 9'h000);
    reset = 1'b1;
    cycle(2);

    // Posedge on pin 0: sync after 2 edges, request after 3, held until ready.
    pin_in = 8'h01;
    cycle(2);
    check("t1_sync", {1'b0, pin_sync}, 9'h001);
    check("t1_not_yet", ir_valid, 9'h000);
    cycle(1);
    check("t1_valid", ir_valid, 9'h001);
    cycle(5);
    check("t1_hold", ir_valid, 9'h001);
    ir_ready = 9'h001; cycle(1); ir_ready = '0;
    check("t1_ack", ir_valid, 9'h000);
    check("t1_ovr", ir_overrun, 9'h000);

    // Negedge on pin 3, then disarmed by dir, by ie, and ie toggling.
    trig = 16'h5595;
    pin_in = 8'h09; cycle(3);
    pin_in = 8'h01; cycle(3);
    check("t2_neg", ir_valid, 9'h008);
    ir_ready = 9'h008; cycle(1); ir_ready = '0;
    dir = 8'h08;
    pin_in = 8'h09; cycle(3); pin_in = 8'h01; cycle(4);
    check("t2_dir", ir_valid, 9'h000);
    dir = '0; ie = 8'hF7;
    pin_in = 8'h09; cycle(3); pin_in = 8'h01; cycle(4);
    check("t2_ie", ir_valid, 9'h000);
    ie = 8'hFF; cycle(2); ie = 8'hF7; cycle(1); ie = 8'hFF; cycle(3);
    check("t2_toggle", ir_valid, 9'h000);

    // High level on pin 5 re-raises through handshakes.
    trig = 16'h5D55;
    pin_in = 8'h21; cycle(3);
    check("t3_level", ir_valid, 9'h020);
    ir_ready = 9'h020; cycle(1);
    check("t3_prio", ir_valid, 9'h020);
    cycle(1); ir_ready = '0; cycle(2);
    pin_in = 8'h01; ir_ready = 9'h020; cycle(4); ir_ready = '0; cycle(1);
    check("t3_release", ir_valid, 9'h000);
    check("t3_ovr_clr", ir_overrun, 9'h000);

    // Two posedges on pin 1 without ack -> overrun.
    trig = 16'h5555;
    pin_in = 8'h03; cycle(4); pin_in = 8'h01; cycle(2); pin_in = 8'h03; cycle(4);
    check("t4_ovr", ir_overrun, 9'h002);
    check("t4_valid", ir_valid, 9'h002);
    ir_ready = 9'h002; cycle(1); ir_ready = '0;
    check("t4_ack_v", ir_valid, 9'h000);
    check("t4_ack_o", ir_overrun, 9'h000);

    // All-pins mode.
    all_mode = 1'b1; en = 8'h0F;
    pin_in = 8'h00; cycle(4); pin_in = 8'h07; cycle(4);
    check("t5_partial", ir_valid, 9'h000);
    pin_in = 8'h00; cycle(4); pin_in = 8'h0F; cycle(4);
    check("t5_all", ir_valid, 9'h100);
    ir_ready = 9'h100; cycle(1); ir_ready = '0;
    en = 8'h00; pin_in = 8'h00; cycle(3); pin_in = 8'hFF; cycle(4);
    check("t5_none", ir_valid, 9'h000);

    // Reset mid-operation, then synchroniser ramp-up.
    all_mode = 1'b0; en = 8'hFF;
    pin_in = 8'h00; cycle(4); pin_in = 8'h05; cycle(4);
    all_mode = 1'b1; pin_in = 8'h00; cycle(4); pin_in = 8'hFF; cycle(4);
    check("t6_pend", ir_valid, 9'h105);
    reset = 1'b0; cycle(1);
    check("t6_rst_v", ir_valid, 9'h000);
    check("t6_rst_o", ir_overrun, 9'h000);
    check("t6_rst_s", {1'b0, pin_sync}, 9'h000);
    all_mode = 1'b0; reset = 1'b1; cycle(6);
    check("t6_ramp", ir_valid, 9'h0FF);
    ir_ready = 9'h1FF; cycle(1); ir_ready = '0; cycle(4);
    check("t6_once", ir_valid, 9'h000);

    // Randomized traffic checked every cycle against the model.
    for (int r = 0; r < 400; r++) begin
      pin_in = ($urandom_range(0, 3) == 0) ? W'($urandom) : pin_in;
      if ($urandom_range(0, 15) == 0) begin
        trig = 16'($urandom);
        dir = W'($urandom) & W'($urandom);
        en = W'($urandom) | W'($urandom);
        ie = W'($urandom) | W'($urandom);
        all_mode = ($urandom_range(0, 3) == 0);
      end
      ir_ready = (W+1)'($urandom) & (W+1)'($urandom);
      reset = ($urandom_range(0, 99) != 0);
      cycle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
